regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the core's integer register file. It has one clock and reset, and shares the register file's single write port between two write-back requesters: req0 (EXU/ALU result) and req1 (LSU load result). Arbitration is round-robin over a valid/ready handshake. The block also keeps a per-register busy scoreboard, so issue logic can stall on read-after-write hazards. It sits between the EXU/LSU write-back paths and the register file's `wen/waddr/wdata` inputs.

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Purpose : round-robin arbiter sharing the register file write port between EXU (req0) and LSU (req1), plus a per-register busy scoreboard.
// Latency : handshake in cycle N drives rf_wen/rf_waddr/rf_wdata in N+1; the busy bit clears at the end of N+1.
// Backpr. : ready is granted to at most one requester per cycle; the output stage never stalls.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqX_valid/addr/data, reqX_ready write-back requesters (X = 0 EXU, 1 LSU)
//   rf_wen/rf_waddr/rf_wdata        registered register-file write port
//   sb_set/sb_set_addr              issue stage marks a destination pending
//   chk_addr/chk_busy               combinational busy query for decode
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  sb_set,
  input  logic [ADDR_WIDTH-1:0] sb_set_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  output logic                  chk_busy
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic                  r_prio;     // 0: req0 preferred, 1: req1 preferred
  logic [NREGS-1:0]      r_busy;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_hs0;
  logic                  w_hs1;
  logic [NREGS-1:0]      w_busy_nxt;

  // Grant depends only on valids and the rotation pointer, never on ready.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (r_prio) w_gnt1 = 1'b1;
      else        w_gnt0 = 1'b1;
    end else if (req0_valid) begin
      w_gnt0 = 1'b1;
    end else if (req1_valid) begin
      w_gnt1 = 1'b1;
    end
  end

  // Gating with rst_n keeps both readies low for the whole reset window.
  assign req0_ready = w_gnt0 & rst_n;
  assign req1_ready = w_gnt1 & rst_n;
  assign w_hs0      = req0_valid & req0_ready;
  assign w_hs1      = req1_valid & req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_prio  <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      if (w_hs0) begin
        r_wen   <= (req0_addr != '0);
        r_waddr <= req0_addr;
        r_wdata <= req0_data;
        r_prio  <= 1'b1;
      end else if (w_hs1) begin
        r_wen   <= (req1_addr != '0);
        r_waddr <= req1_addr;
        r_wdata <= req1_data;
        r_prio  <= 1'b0;
      end
    end
  end

  // Clear is applied first so a same-cycle set of the same register wins:
  // the newer producer is still in flight.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen) w_busy_nxt[r_waddr] = 1'b0;
    if (sb_set && (sb_set_addr != '0)) w_busy_nxt[sb_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign chk_busy = r_busy[chk_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose : directed self-checking bench for regfile_wb_arbiter.
// Latency : inputs driven 1ns after posedge, outputs sampled before the next edge.
// Backpr. : requesters hold valid until their grant is observed.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic [4:0]  chk_addr;
  logic        chk_busy;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .chk_addr(chk_addr), .chk_busy(chk_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    sb_set = 0; sb_set_addr = 0; chk_addr = 0;
    #2;
    chk("reset_wen",   {31'd0, rf_wen}, 0);
    chk("reset_waddr", {27'd0, rf_waddr}, 0);
    chk("reset_wdata", rf_wdata, 0);
    #10 rst_n = 1'b1;
    tick;

    // Single write from req0
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    #1;
    chk("single_rdy0", {31'd0, req0_ready}, 1);
    chk("single_rdy1", {31'd0, req1_ready}, 0);
    tick;
    req0_valid = 0;
    chk("single_wen",   {31'd0, rf_wen}, 1);
    chk("single_waddr", {27'd0, rf_waddr}, 5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    tick;
    chk("single_wen_drop", {31'd0, rf_wen}, 0);
    chk("single_waddr_hold", {27'd0, rf_waddr}, 5);
    chk("single_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // Short async reset pulse so contention starts with req0 preferred
    #2 rst_n = 0;
    #1 rst_n = 1;
    #1;

    // Contention: grants strictly alternate starting with req0
    req0_valid = 1; req0_addr = 1; req0_data = 32'h11;
    req1_valid = 1; req1_addr = 2; req1_data = 32'h22;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("cont_rdy0_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_rdy1_%0d", i), {31'd0, req1_ready}, (i % 2 == 0) ? 0 : 1);
      if (i > 0) begin
        chk($sformatf("cont_wen_%0d", i),   {31'd0, rf_wen}, 1);
        chk($sformatf("cont_waddr_%0d", i), {27'd0, rf_waddr}, (i % 2 == 1) ? 1 : 2);
      end
      tick;
    end
    req0_valid = 0; req1_valid = 0;
    chk("cont_last_waddr", {27'd0, rf_waddr}, 2);
    chk("cont_last_wdata", rf_wdata, 32'h22);

    // Scoreboard lifecycle on reg 7
    sb_set = 1; sb_set_addr = 7; chk_addr = 7;
    #1;
    chk("sb7_before", {31'd0, chk_busy}, 0);
    tick;
    sb_set = 0;
    #1;
    chk("sb7_set", {31'd0, chk_busy}, 1);
    req1_valid = 1; req1_addr = 7; req1_data = 32'h77;
    #1;
    chk("sb7_rdy1", {31'd0, req1_ready}, 1);
    tick;
    req1_valid = 0;
    chk("sb7_wen",   {31'd0, rf_wen}, 1);
    chk("sb7_waddr", {27'd0, rf_waddr}, 7);
    chk("sb7_busy_n1", {31'd0, chk_busy}, 1);
    tick;
    chk("sb7_busy_n2", {31'd0, chk_busy}, 0);

    // Set/clear collision on reg 4
    sb_set = 1; sb_set_addr = 4; chk_addr = 4;
    tick;
    sb_set = 0;
    req0_valid = 1; req0_addr = 4; req0_data = 32'h44;
    tick;
    req0_valid = 0;
    sb_set = 1; sb_set_addr = 4;
    #1;
    chk("coll_wen",   {31'd0, rf_wen}, 1);
    chk("coll_waddr", {27'd0, rf_waddr}, 4);
    chk("coll_busy_during", {31'd0, chk_busy}, 1);
    tick;
    sb_set = 0;
    chk("coll_busy_after", {31'd0, chk_busy}, 1);
    tick;
    chk("coll_busy_later", {31'd0, chk_busy}, 1);

    // x0 handling
    sb_set = 1; sb_set_addr = 0; chk_addr = 0;
    tick;
    sb_set = 0;
    chk("x0_busy", {31'd0, chk_busy}, 0);
    req1_valid = 1; req1_addr = 10; req1_data = 32'hA;   // leaves req0 preferred
    tick;
    req1_valid = 0;
    req0_valid = 1; req0_addr = 0; req0_data = 32'h55;
    #1;
    chk("x0_rdy0", {31'd0, req0_ready}, 1);
    tick;
    req0_valid = 0;
    chk("x0_wen",   {31'd0, rf_wen}, 0);
    chk("x0_waddr", {27'd0, rf_waddr}, 0);
    req0_valid = 1; req0_addr = 1; req0_data = 32'h1;
    req1_valid = 1; req1_addr = 2; req1_data = 32'h2;
    #1;
    chk("x0_tie_rdy0", {31'd0, req0_ready}, 0);
    chk("x0_tie_rdy1", {31'd0, req1_ready}, 1);
    req0_valid = 0; req1_valid = 0;

    // Reset mid-operation with busy regs 3 and 9 and both valids held
    tick;
    sb_set = 1; sb_set_addr = 3;
    tick;
    sb_set_addr = 9;
    tick;
    sb_set = 0; chk_addr = 3;
    req0_valid = 1; req0_addr = 1; req0_data = 32'hAAAA;
    req1_valid = 1; req1_addr = 2; req1_data = 32'hBBBB;
    #1;
    chk("rst_pre_busy3", {31'd0, chk_busy}, 1);
    tick;
    chk("rst_pre_wen", {31'd0, rf_wen}, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_wen",   {31'd0, rf_wen}, 0);
    chk("rst_waddr", {27'd0, rf_waddr}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_rdy0",  {31'd0, req0_ready}, 0);
    chk("rst_rdy1",  {31'd0, req1_ready}, 0);
    chk("rst_busy3", {31'd0, chk_busy}, 0);
    chk_addr = 9;
    #1;
    chk("rst_busy9", {31'd0, chk_busy}, 0);
    tick;
    chk("rst_hold_wen", {31'd0, rf_wen}, 0);
    #1 rst_n = 1;
    #1;
    chk("rel_rdy0", {31'd0, req0_ready}, 1);
    chk("rel_rdy1", {31'd0, req1_ready}, 0);
    tick;
    chk("rel_waddr", {27'd0, rf_waddr}, 1);
    chk("rel_wdata", rf_wdata, 32'hAAAA);
    req0_valid = 0; req1_valid = 0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
